// File: rtl/bfis_query_sched.sv
// Round-robin query scheduler feeding one bfis search engine.
// Optional watchdog in WAIT_RESULT: define BFIS_TIMEOUT_EN.
module bfis_query_sched #(
  parameter int NUM_REQ        = 2,
  parameter int DIM            = 4,
  parameter int K_OUT          = 5,
  parameter int MEM_LATENCY    = 2,
  parameter int ISSUE_GAP      = 1,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int ID_W          = $clog2(NUM_REQ)
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [NUM_REQ-1:0] req_valid_in,
  output logic [NUM_REQ-1:0] req_ready_out,
  input  logic [31:0]        req_query_in [NUM_REQ][DIM],
  input  logic [15:0]        req_k_in [NUM_REQ],
  input  logic [31:0]        req_base_addr_in [NUM_REQ],
  input  logic [15:0]        req_count_in [NUM_REQ],
  output logic               mem_rd_out,
  output logic [31:0]        mem_addr_out,
  input  logic [31:0]        mem_data_in,
  output logic               eng_rst_out,
  output logic [31:0]        eng_query_out [DIM],
  output logic [15:0]        eng_k_out,
  output logic [31:0]        eng_vertex_out,
  output logic [31:0]        eng_vertex_addr_out,
  output logic               eng_vertex_valid_out,
  input  logic               eng_valid_in,
  input  logic [31:0]        eng_top_k_in [K_OUT],
  output logic               resp_valid_out,
  input  logic               resp_ready_in,
  output logic [ID_W-1:0]    resp_id_out,
  output logic [31:0]        resp_top_k_out [K_OUT],
  output logic               resp_err_out,
  output logic               busy_out
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 16) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FETCH,
    S_DRAIN,
    S_WAIT,
    S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [31:0]      query_q [DIM];
  logic [31:0]      query_d [DIM];
  logic [15:0]      k_q, k_d;
  logic [31:0]      base_q, base_d;
  logic [15:0]      count_q, count_d;
  logic [15:0]      n_q, n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      topk_q [K_OUT];
  logic [31:0]      topk_d [K_OUT];
  logic             err_q, err_d;

  logic [MEM_LATENCY-1:0] pv_q, pv_d;
  logic [31:0]            pa_q [MEM_LATENCY];
  logic [31:0]            pa_d [MEM_LATENCY];

  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;

  // First valid requester strictly after the last one served.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int o = 1; o <= NUM_REQ; o++) begin
      idx = (int'(rr_q) + o) % NUM_REQ;
      if (!gnt_found && req_valid_in[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    id_d          = id_q;
    query_d       = query_q;
    k_d           = k_q;
    base_d        = base_q;
    count_d       = count_q;
    n_d           = n_q;
    cnt_d         = cnt_q;
    topk_d        = topk_q;
    err_d         = err_q;
    req_ready_out = '0;
    mem_rd_out    = 1'b0;
    mem_addr_out  = '0;
    eng_rst_out   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          req_ready_out[gnt_idx] = 1'b1;
          rr_d    = gnt_idx;
          id_d    = gnt_idx;
          query_d = req_query_in[gnt_idx];
          k_d     = req_k_in[gnt_idx];
          base_d  = req_base_addr_in[gnt_idx];
          count_d = req_count_in[gnt_idx];
          n_d     = '0;
          cnt_d   = '0;
          if (req_count_in[gnt_idx] == 16'd0) begin
            topk_d  = '{default: '1};
            err_d   = 1'b0;
            state_d = S_RESP;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        eng_rst_out = 1'b1;
        cnt_d       = '0;
        state_d     = S_FETCH;
      end
      S_FETCH: begin
        if (cnt_q == '0) begin
          mem_rd_out   = 1'b1;
          mem_addr_out = base_q + {16'b0, n_q};
          n_d          = n_q + 16'd1;
          if (n_q == count_q - 16'd1) begin
            cnt_d   = CNT_W'(MEM_LATENCY - 1);
            state_d = S_DRAIN;
          end else begin
            cnt_d = CNT_W'(ISSUE_GAP);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DRAIN: begin
        // Leaves on the cycle the last beat leaves the pipe.
        if (cnt_q == '0) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT: begin
        if (eng_valid_in) begin
          topk_d  = eng_top_k_in;
          err_d   = 1'b0;
          state_d = S_RESP;
        end
`ifdef BFIS_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          topk_d  = '{default: '1};
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        if (resp_ready_in) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read strobe and address travel together to meet the data.
  always_comb begin
    pv_d    = '0;
    pa_d    = pa_q;
    pv_d[0] = mem_rd_out;
    pa_d[0] = mem_addr_out;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pa_d[i] = pa_q[i-1];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      rr_q    <= ID_W'(NUM_REQ - 1);
      id_q    <= '0;
      query_q <= '{default: '0};
      k_q     <= '0;
      base_q  <= '0;
      count_q <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      topk_q  <= '{default: '1};
      err_q   <= 1'b0;
      pv_q    <= '0;
      pa_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      query_q <= query_d;
      k_q     <= k_d;
      base_q  <= base_d;
      count_q <= count_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      topk_q  <= topk_d;
      err_q   <= err_d;
      pv_q    <= pv_d;
      pa_q    <= pa_d;
    end
  end

  assign eng_query_out        = query_q;
  assign eng_k_out            = k_q;
  assign eng_vertex_valid_out = pv_q[MEM_LATENCY-1];
  assign eng_vertex_addr_out  = pa_q[MEM_LATENCY-1];
  assign eng_vertex_out       = pv_q[MEM_LATENCY-1] ? mem_data_in : '0;
  assign resp_valid_out       = (state_q == S_RESP);
  assign resp_id_out          = id_q;
  assign resp_top_k_out       = topk_q;
  assign resp_err_out         = err_q;
  assign busy_out             = (state_q != S_IDLE);

endmodule

// File: tb/tb_bfis_query_sched.sv
// Bench for bfis_query_sched: BRAM and engine models,
// table vectors, random queries, reset and timeout cases.
module tb_bfis_query_sched;

  localparam int NR  = 2;
  localparam int DIM = 4;
  localparam int KO  = 5;
  localparam int LAT = 2;
  localparam int GAP = 1;
  localparam int TO  = 100;
  localparam int IDW = 1;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic            rst_n_in;
  logic [NR-1:0]   req_valid_in;
  logic [NR-1:0]   req_ready_out;
  logic [31:0]     req_query_in [NR][DIM];
  logic [15:0]     req_k_in [NR];
  logic [31:0]     req_base_addr_in [NR];
  logic [15:0]     req_count_in [NR];
  logic            mem_rd_out;
  logic [31:0]     mem_addr_out;
  logic [31:0]     mem_data_in;
  logic            eng_rst_out;
  logic [31:0]     eng_query_out [DIM];
  logic [15:0]     eng_k_out;
  logic [31:0]     eng_vertex_out;
  logic [31:0]     eng_vertex_addr_out;
  logic            eng_vertex_valid_out;
  logic            eng_valid_in;
  logic [31:0]     eng_top_k_in [KO];
  logic            resp_valid_out;
  logic            resp_ready_in;
  logic [IDW-1:0]  resp_id_out;
  logic [31:0]     resp_top_k_out [KO];
  logic            resp_err_out;
  logic            busy_out;

  bfis_query_sched #(
    .NUM_REQ(NR), .DIM(DIM), .K_OUT(KO),
    .MEM_LATENCY(LAT), .ISSUE_GAP(GAP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .req_valid_in(req_valid_in),
    .req_ready_out(req_ready_out),
    .req_query_in(req_query_in),
    .req_k_in(req_k_in),
    .req_base_addr_in(req_base_addr_in),
    .req_count_in(req_count_in),
    .mem_rd_out(mem_rd_out),
    .mem_addr_out(mem_addr_out),
    .mem_data_in(mem_data_in),
    .eng_rst_out(eng_rst_out),
    .eng_query_out(eng_query_out),
    .eng_k_out(eng_k_out),
    .eng_vertex_out(eng_vertex_out),
    .eng_vertex_addr_out(eng_vertex_addr_out),
    .eng_vertex_valid_out(eng_vertex_valid_out),
    .eng_valid_in(eng_valid_in),
    .eng_top_k_in(eng_top_k_in),
    .resp_valid_out(resp_valid_out),
    .resp_ready_in(resp_ready_in),
    .resp_id_out(resp_id_out),
    .resp_top_k_out(resp_top_k_out),
    .resp_err_out(resp_err_out),
    .busy_out(busy_out)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] t [4];
    t = '{32'h348, 32'h18A, 32'h30F, 32'h31E};
    if (a >= 32'h10 && a <= 32'h13) return t[a[1:0]];
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Fixed-latency BRAM
  logic [31:0] bp [LAT];
  always @(posedge clk_in) begin
    bp[0] <= mem_addr_out;
    for (int i = 1; i < LAT; i++) bp[i] <= bp[i-1];
  end
  assign mem_data_in = mem_word(bp[LAT-1]);

  // Monitor logs and engine stub
  int          cyc = 0;
  int          grant_q[$];
  int          grant_cyc, resp_cyc, rst_cyc;
  int          rst_cnt;
  logic [31:0] rd_q[$];
  logic [31:0] beat_a[$];
  logic [31:0] beat_d[$];
  int          beat_c[$];
  logic [31:0] got[$];
  logic        resp_prev = 1'b0;
  bit          eng_auto  = 1'b1;
  bit          eng_force = 1'b0;
  bit          fired     = 1'b1;
  int          dly;
  int          eng_expect;
  logic [31:0] eng_fixed [KO];
  int          ref_rr;

  initial begin
    eng_valid_in = 1'b0;
    for (int j = 0; j < KO; j++) eng_top_k_in[j] = '0;
    forever begin
      @(negedge clk_in);
      cyc++;
      eng_valid_in = 1'b0;
      if (!rst_n_in) begin
        got.delete();
        fired = 1'b1;
      end
      if (req_ready_out != '0) begin
        chk("ready_onehot", $countones(req_ready_out), 1);
        chk("ready_in_idle", busy_out, 0);
        for (int i = 0; i < NR; i++)
          if (req_ready_out[i]) grant_q.push_back(i);
        grant_cyc = cyc;
      end
      if (eng_rst_out) begin
        rst_cnt++;
        rst_cyc = cyc;
        got.delete();
        fired = 1'b0;
        dly   = 3;
      end
      if (mem_rd_out) rd_q.push_back(mem_addr_out);
      if (eng_vertex_valid_out) begin
        beat_a.push_back(eng_vertex_addr_out);
        beat_d.push_back(eng_vertex_out);
        beat_c.push_back(cyc);
        got.push_back(eng_vertex_out);
      end
      if (resp_valid_out && !resp_prev) resp_cyc = cyc;
      resp_prev = resp_valid_out;
      if (eng_auto && !fired && got.size() == eng_expect) begin
        if (dly == 0) begin
          logic [31:0] s;
          s = '0;
          foreach (got[i]) s += got[i];
          for (int j = 0; j < KO; j++)
            eng_top_k_in[j] = eng_force ? eng_fixed[j] :
              s + 32'(eng_k_out) + eng_query_out[j % DIM];
          eng_valid_in = 1'b1;
          fired = 1'b1;
        end else begin
          dly--;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_logs();
    grant_q.delete();
    rd_q.delete();
    beat_a.delete();
    beat_d.delete();
    beat_c.delete();
    rst_cnt = 0;
  endtask

  task automatic set_req(input int i, input logic [31:0] base,
                         input logic [15:0] cnt, input logic [15:0] k);
    req_base_addr_in[i] = base;
    req_count_in[i]     = cnt;
    req_k_in[i]         = k;
    for (int d = 0; d < DIM; d++)
      req_query_in[i][d] = 32'(k) * 7 + 32'(d) + 32'(i * 100);
  endtask

  function automatic int rr_pick(input logic [NR-1:0] m);
    for (int o = 1; o <= NR; o++) begin
      int idx;
      idx = (ref_rr + o) % NR;
      if (m[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check_reset_outs();
    int qbad, tbad;
    qbad = 0;
    tbad = 0;
    for (int d = 0; d < DIM; d++) if (eng_query_out[d] != 0) qbad++;
    for (int j = 0; j < KO; j++)
      if (resp_top_k_out[j] != 32'hFFFF_FFFF) tbad++;
    chk("rst_ready", req_ready_out, 0);
    chk("rst_mem_rd", mem_rd_out, 0);
    chk("rst_mem_addr", mem_addr_out, 0);
    chk("rst_eng_rst", eng_rst_out, 0);
    chk("rst_query", qbad, 0);
    chk("rst_k", eng_k_out, 0);
    chk("rst_vtx", {eng_vertex_out, eng_vertex_addr_out}, 0);
    chk("rst_vtx_valid", eng_vertex_valid_out, 0);
    chk("rst_resp_valid", resp_valid_out, 0);
    chk("rst_resp_id", resp_id_out, 0);
    chk("rst_top_k", tbad, 0);
    chk("rst_err", resp_err_out, 0);
    chk("rst_busy", busy_out, 0);
  endtask

  task automatic run_query(input logic [NR-1:0] mask, input int exp_id,
                           input int hold);
    int t, cnt, bad, sbad;
    logic [31:0] base, s;
    logic [31:0] e [KO];
    logic [31:0] snap [KO];
    clear_logs();
    eng_expect   = int'(req_count_in[exp_id]);
    req_valid_in = mask;
    t = 0;
    while (grant_q.size() == 0 && t < 20) begin
      step();
      t++;
    end
    chk("grant_seen", grant_q.size() != 0, 1);
    if (grant_q.size() == 0) return;
    chk("grant_id", grant_q[0], exp_id);
    ref_rr = exp_id;
    t = 0;
    while (!resp_valid_out && t < 300) begin
      step();
      t++;
    end
    chk("resp_seen", resp_valid_out, 1);
    if (!resp_valid_out) return;
    cnt  = int'(req_count_in[exp_id]);
    base = req_base_addr_in[exp_id];
    s    = '0;
    for (int n = 0; n < cnt; n++) s += mem_word(base + 32'(n));
    for (int j = 0; j < KO; j++) begin
      if (cnt == 0) e[j] = 32'hFFFF_FFFF;
      else if (eng_force) e[j] = eng_fixed[j];
      else e[j] = s + 32'(req_k_in[exp_id]) +
                  req_query_in[exp_id][j % DIM];
    end
    chk("resp_id", resp_id_out, exp_id);
    chk("eng_rst_pulses", rst_cnt, (cnt > 0) ? 1 : 0);
    chk("rd_count", rd_q.size(), cnt);
    chk("beat_count", beat_d.size(), cnt);
    bad = 0;
    for (int n = 0; n < cnt && n < rd_q.size(); n++)
      if (rd_q[n] != base + 32'(n)) bad++;
    for (int n = 0; n < cnt && n < beat_d.size(); n++) begin
      if (beat_a[n] != base + 32'(n)) bad++;
      if (beat_d[n] != mem_word(base + 32'(n))) bad++;
      if (n > 0 && beat_c[n] - beat_c[n-1] != GAP + 1) bad++;
    end
    chk("beat_stream", bad, 0);
    if (cnt > 0 && beat_c.size() > 0)
      chk("first_beat_lat", beat_c[0] - rst_cyc, 1 + LAT);
    if (cnt == 0)
      chk("zero_cnt_lat", (resp_cyc - grant_cyc) <= 2, 1);
    for (int j = 0; j < KO; j++) chk("resp_top_k", resp_top_k_out[j], e[j]);
    chk("resp_err", resp_err_out, 0);
    snap = resp_top_k_out;
    sbad = 0;
    for (int h = 0; h < hold; h++) begin
      step();
      if (!resp_valid_out || resp_id_out != IDW'(exp_id)) sbad++;
      for (int j = 0; j < KO; j++) if (resp_top_k_out[j] != snap[j]) sbad++;
    end
    if (hold > 0) chk("resp_stable", sbad, 0);
    chk("no_regrant", grant_q.size(), 1);
    resp_ready_in = 1'b1;
    step();
    resp_ready_in = 1'b0;
    #3;
    chk("idle_after_hs", busy_out, 0);
    chk("resp_dropped", resp_valid_out, 0);
  endtask

  typedef struct {
    logic [NR-1:0] mask;
    logic [31:0]   base;
    logic [15:0]   c0;
    logic [15:0]   c1;
    logic [15:0]   k;
    int            exp_id;
    int            hold;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NR-1:0] m;
    int t;
    tbl[0] = '{2'b11, 32'h100, 16'd3, 16'd2, 16'd9, 1, 0};
    tbl[1] = '{2'b11, 32'h140, 16'd2, 16'd3, 16'd10, 0, 1};
    tbl[2] = '{2'b11, 32'h180, 16'd1, 16'd4, 16'd11, 1, 0};
    tbl[3] = '{2'b11, 32'h1C0, 16'd4, 16'd1, 16'd12, 0, 2};
    tbl[4] = '{2'b10, 32'h200, 16'd5, 16'd0, 16'd13, 1, 0};
    tbl[5] = '{2'b01, 32'hFFFF_FFFE, 16'd4, 16'd2, 16'd14, 0, 0};
    tbl[6] = '{2'b11, 32'h240, 16'd2, 16'd1, 16'd15, 1, 0};
    tbl[7] = '{2'b10, 32'h280, 16'd1, 16'd3, 16'd16, 1, 0};

    rst_n_in      = 1'b0;
    req_valid_in  = '0;
    resp_ready_in = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 32'h0, 16'd0, 16'd0);
    eng_fixed = '{32'h3BF, 32'h3C0, 32'h400, 32'h410, 32'h500};
    ref_rr = NR - 1;

    repeat (3) step();
    #3;
    check_reset_outs();
    rst_n_in = 1'b1;
    step();

    // Single query with known memory and engine result
    set_req(0, 32'h10, 16'd4, 16'd4);
    req_query_in[0] = '{32'd5, 32'd7, 32'd1, 32'd1};
    eng_force = 1'b1;
    run_query(2'b01, 0, 0);
    chk("eng_query0", eng_query_out[0], 5);
    chk("eng_query1", eng_query_out[1], 7);
    chk("eng_k", eng_k_out, 4);
    eng_force = 1'b0;

    for (int v = 0; v < 8; v++) begin
      set_req(0, tbl[v].base, tbl[v].c0, tbl[v].k);
      set_req(1, tbl[v].base + 32'h20, tbl[v].c1, tbl[v].k + 16'd1);
      run_query(tbl[v].mask, tbl[v].exp_id, tbl[v].hold);
    end

    // Long backpressure with the other requester waiting
    set_req(0, 32'h300, 16'd2, 16'd21);
    set_req(1, 32'h340, 16'd2, 16'd22);
    run_query(2'b11, rr_pick(2'b11), 20);

    for (int it = 0; it < 12; it++) begin
      m = NR'($urandom_range(1, 3));
      for (int i = 0; i < NR; i++)
        set_req(i,
          ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom(),
          16'($urandom_range(0, 5)), 16'($urandom_range(0, 65535)));
      run_query(m, rr_pick(m), $urandom_range(0, 3));
    end
    req_valid_in = '0;
    step();

`ifdef BFIS_TIMEOUT_EN
    eng_auto = 1'b0;
    clear_logs();
    set_req(0, 32'h500, 16'd1, 16'd5);
    req_valid_in = 2'b01;
    t = 0;
    while (!resp_valid_out && t < 400) begin
      step();
      t++;
    end
    req_valid_in = '0;
    chk("to_resp_seen", resp_valid_out, 1);
    chk("to_err", resp_err_out, 1);
    chk("to_top_k0", resp_top_k_out[0], 32'hFFFF_FFFF);
    if (beat_c.size() > 0)
      chk("to_latency", resp_cyc - beat_c[beat_c.size()-1], TO + 1);
    resp_ready_in = 1'b1;
    step();
    resp_ready_in = 1'b0;
    eng_auto = 1'b1;
    step();
`endif

    // Reset in the middle of streaming
    clear_logs();
    set_req(0, 32'h400, 16'd4, 16'd3);
    eng_expect   = 4;
    req_valid_in = 2'b01;
    t = 0;
    while (rd_q.size() < 2 && t < 30) begin
      step();
      t++;
    end
    chk("two_reads_seen", rd_q.size(), 2);
    req_valid_in = '0;
    rst_n_in     = 1'b0;
    step();
    #3;
    check_reset_outs();
    rst_n_in = 1'b1;
    clear_logs();
    repeat (8) step();
    chk("no_stray_beat", beat_d.size(), 0);
    chk("no_stray_rd", rd_q.size(), 0);
    chk("no_resp_after_rst", resp_valid_out, 0);
    ref_rr = NR - 1;
    set_req(0, 32'h440, 16'd3, 16'd7);
    set_req(1, 32'h480, 16'd2, 16'd8);
    run_query(2'b11, rr_pick(2'b11), 0);
    req_valid_in = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
